// File: rtl/ncc_scan_ctrl.sv
// rtl/ncc_scan_ctrl.sv - descriptor load / window prime / scan sequencer for the NCC PE grid
// Tags each match position with (x,y) and re-emits it PE_LAT cycles after its column accept.
module ncc_scan_ctrl #(
    parameter int DESC_DIM     = 16,
    parameter int PIX_PER_WORD = 4,
    parameter int WIN_W        = 640,
    parameter int WIN_H        = 640,
    parameter int PE_LAT       = 16,
    localparam int NGRP        = DESC_DIM / PIX_PER_WORD,
    localparam int ROW_W       = (DESC_DIM > 1) ? $clog2(DESC_DIM) : 1,
    localparam int GRP_W       = (NGRP > 1) ? $clog2(NGRP) : 1,
    localparam int SX_W        = (WIN_W > 1) ? $clog2(WIN_W) : 1,
    localparam int SY_W        = (WIN_H > 1) ? $clog2(WIN_H) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             desc_valid,
    output logic             desc_ready,
    output logic [ROW_W-1:0] desc_row,
    output logic [GRP_W-1:0] desc_grp,
    output logic             desc_load_en,
    input  logic             win_valid,
    output logic             win_ready,
    output logic             pe_shift_en,
    output logic             score_valid,
    output logic [SX_W-1:0]  score_x,
    output logic [SY_W-1:0]  score_y,
    output logic             busy,
    output logic             done
);

    localparam int XMAX = WIN_W - DESC_DIM;
    localparam int YMAX = WIN_H - DESC_DIM;
    localparam int XC_W = (XMAX > 0) ? $clog2(XMAX + 1) : 1;
    localparam int YC_W = (YMAX > 0) ? $clog2(YMAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DESC_LOAD,
        S_WIN_FILL,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ROW_W-1:0]  r_row;
    logic [GRP_W-1:0]  r_grp;
    logic [ROW_W-1:0]  r_fill;
    logic [XC_W-1:0]   r_x;
    logic [YC_W-1:0]   r_y;

    logic [PE_LAT-1:0] r_pv;
    logic [SX_W-1:0]   r_px [PE_LAT];
    logic [SY_W-1:0]   r_py [PE_LAT];
    logic [PE_LAT-1:0] w_pv_head;

    logic              w_desc_last;
    logic              w_fill_last;
    logic              w_scan_row_end;
    logic              w_y_last;
    logic              w_pipe_busy;
    logic              w_push;
    logic [SX_W-1:0]   w_push_x;
    logic [SY_W-1:0]   w_push_y;

    assign w_desc_last    = (r_row == ROW_W'(DESC_DIM - 1)) && (r_grp == GRP_W'(NGRP - 1));
    assign w_fill_last    = (r_fill == ROW_W'(DESC_DIM - 1));
    assign w_scan_row_end = (r_x == XC_W'(XMAX - 1));
    assign w_y_last       = (r_y == YC_W'(YMAX));

    // The oldest stage is leaving this cycle, so only younger stages keep DRAIN waiting.
    assign w_pv_head   = r_pv << 1;
    assign w_pipe_busy = |w_pv_head;

    assign desc_load_en = desc_valid & desc_ready;
    assign pe_shift_en  = win_valid & win_ready;
    assign desc_row     = (r_state == S_DESC_LOAD) ? r_row : '0;
    assign desc_grp     = (r_state == S_DESC_LOAD) ? r_grp : '0;

    assign score_valid = r_pv[PE_LAT-1];
    assign score_x     = r_px[PE_LAT-1];
    assign score_y     = r_py[PE_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        desc_ready  = 1'b0;
        win_ready   = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        w_push      = 1'b0;
        w_push_x    = '0;
        w_push_y    = SY_W'(r_y);
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_DESC_LOAD;
            end
            S_DESC_LOAD: begin
                desc_ready = 1'b1;
                if (desc_valid && w_desc_last) w_state_nxt = S_WIN_FILL;
            end
            S_WIN_FILL: begin
                win_ready = 1'b1;
                if (win_valid && w_fill_last) begin
                    w_push = 1'b1;
                    if (XMAX != 0)    w_state_nxt = S_SCAN;
                    else if (w_y_last) w_state_nxt = S_DRAIN;
                end
            end
            S_SCAN: begin
                win_ready = 1'b1;
                if (win_valid) begin
                    w_push   = 1'b1;
                    w_push_x = SX_W'(r_x) + SX_W'(1);
                    if (w_scan_row_end) w_state_nxt = w_y_last ? S_DRAIN : S_WIN_FILL;
                end
            end
            S_DRAIN: begin
                if (!w_pipe_busy) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_push      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row  <= '0;
            r_grp  <= '0;
            r_fill <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else if (abort || (r_state == S_IDLE && start)) begin
            r_row  <= '0;
            r_grp  <= '0;
            r_fill <= '0;
            r_x    <= '0;
            r_y    <= '0;
        end else begin
            case (r_state)
                S_DESC_LOAD: begin
                    if (desc_valid && !w_desc_last) begin
                        if (r_grp == GRP_W'(NGRP - 1)) begin
                            r_grp <= '0;
                            r_row <= r_row + ROW_W'(1);
                        end else begin
                            r_grp <= r_grp + GRP_W'(1);
                        end
                    end
                end
                S_WIN_FILL: begin
                    if (win_valid) begin
                        if (!w_fill_last) begin
                            r_fill <= r_fill + ROW_W'(1);
                        end else begin
                            r_fill <= '0;
                            if (XMAX == 0 && !w_y_last) r_y <= r_y + YC_W'(1);
                        end
                    end
                end
                S_SCAN: begin
                    if (win_valid) begin
                        if (!w_scan_row_end) begin
                            r_x <= r_x + XC_W'(1);
                        end else if (!w_y_last) begin
                            r_x    <= '0;
                            r_fill <= '0;
                            r_y    <= r_y + YC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < PE_LAT; i++) begin
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            r_pv    <= abort ? '0 : ((r_pv << 1) | PE_LAT'(w_push));
            r_px[0] <= w_push_x;
            r_py[0] <= w_push_y;
            for (int i = 1; i < PE_LAT; i++) begin
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ncc_scan_ctrl.sv
// tb/tb_ncc_scan_ctrl.sv - self-checking bench for ncc_scan_ctrl on a small 18x18 window
module tb_ncc_scan_ctrl;

    localparam int DD  = 16;
    localparam int PPW = 4;
    localparam int WW  = 18;
    localparam int WH  = 18;
    localparam int PL  = 4;
    localparam int NG  = DD / PPW;
    localparam int NW  = DD * NG;
    localparam int XN  = WW - DD + 1;
    localparam int YN  = WH - DD + 1;
    localparam int RA  = DD + XN - 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       desc_valid = 1'b0;
    logic       win_valid = 1'b0;
    logic       desc_ready, desc_load_en, win_ready, pe_shift_en;
    logic       score_valid, busy, done;
    logic [3:0] desc_row;
    logic [1:0] desc_grp;
    logic [4:0] score_x;
    logic [4:0] score_y;

    ncc_scan_ctrl #(
        .DESC_DIM(DD), .PIX_PER_WORD(PPW), .WIN_W(WW), .WIN_H(WH), .PE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_row(desc_row),
        .desc_grp(desc_grp), .desc_load_en(desc_load_en),
        .win_valid(win_valid), .win_ready(win_ready), .pe_shift_en(pe_shift_en),
        .score_valid(score_valid), .score_x(score_x), .score_y(score_y),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {int c; int x; int y;} tag_t;
    tag_t q[$];
    int   cyc = 0;
    int   phase = 0;
    int   dcnt = 0;
    int   wcnt = 0;
    int   done_cyc = -1;
    int   n_pass = 0;
    int   n_chk = 0;
    int   s_cnt = 0;
    int   d_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    // Reference: phases plus run-level counts; position of accept k follows from k / RA and k % RA.
    task automatic cycle();
        bit sv;
        int j;
        int r;
        #1;
        if (!rst_n) begin
            phase = 0;
            q.delete();
        end
        sv = 1'b0;
        if (q.size() > 0) sv = (q[0].c == cyc);
        chk("busy", {31'b0, busy}, {31'b0, phase != 0});
        chk("desc_ready", {31'b0, desc_ready}, {31'b0, phase == 1});
        chk("desc_load_en", {31'b0, desc_load_en}, {31'b0, phase == 1 && desc_valid});
        chk("desc_row", {28'b0, desc_row}, (phase == 1) ? dcnt / NG : 0);
        chk("desc_grp", {30'b0, desc_grp}, (phase == 1) ? dcnt % NG : 0);
        chk("win_ready", {31'b0, win_ready}, {31'b0, phase == 2});
        chk("pe_shift_en", {31'b0, pe_shift_en}, {31'b0, phase == 2 && win_valid});
        chk("done", {31'b0, done}, {31'b0, phase == 4});
        chk("score_valid", {31'b0, score_valid}, {31'b0, sv});
        if (sv) begin
            chk("score_x", {27'b0, score_x}, q[0].x);
            chk("score_y", {27'b0, score_y}, q[0].y);
            void'(q.pop_front());
        end
        if (score_valid === 1'b1) s_cnt++;
        if (done === 1'b1) d_cnt++;
        if (!rst_n || abort) begin
            phase = 0;
            q.delete();
        end else begin
            case (phase)
                0: if (start) begin phase = 1; dcnt = 0; wcnt = 0; end
                1: if (desc_valid) begin
                    dcnt++;
                    if (dcnt == NW) phase = 2;
                end
                2: if (win_valid) begin
                    j = wcnt % RA;
                    r = wcnt / RA;
                    if (j >= DD - 1) begin
                        q.push_back('{cyc + PL, j - (DD - 1), r});
                        if (wcnt + 1 == RA * YN) done_cyc = cyc + PL + 1;
                    end
                    wcnt++;
                    if (wcnt == RA * YN) phase = 3;
                end
                3: if (cyc + 1 == done_cyc) phase = 4;
                default: phase = 0;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_to_idle(input int budget, input int pd, input int pw);
        s_cnt = 0;
        d_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            desc_valid = ($urandom_range(0, 99) < pd);
            win_valid  = ($urandom_range(0, 99) < pw);
            cycle();
            if (phase == 0) break;
        end
        desc_valid = 1'b0;
        win_valid  = 1'b0;
        chk("run_idle_busy", {31'b0, busy}, 0);
        chk("run_positions", s_cnt, XN * YN);
        chk("run_done_pulses", d_cnt, 1);
    endtask

    initial begin
        @(negedge clk);
        repeat (3) cycle();
        rst_n = 1'b1;
        desc_valid = 1'b1;
        repeat (3) cycle();

        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
        desc_valid = 1'b0;
        repeat (2) cycle();

        run_to_idle(400, 100, 100);
        run_to_idle(3000, 60, 50);

        s_cnt = 0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        desc_valid = 1'b1;
        win_valid  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (phase == 2 && wcnt == RA + RA - 1) break;
            cycle();
        end
        chk("abort_in_flight", q.size(), 2);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        s_cnt = 0;
        d_cnt = 0;
        repeat (10) cycle();
        chk("abort_no_score", s_cnt, 0);
        chk("abort_no_done", d_cnt, 0);
        desc_valid = 1'b0;
        win_valid  = 1'b0;

        run_to_idle(3000, 75, 50);

        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        repeat (3) cycle();

        run_to_idle(3000, 90, 30);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
